// File: rtl/rx_controller_ear_pkg.sv
// Shared network package: frame constants, field widths, receiver state encoding
// and the CRC-8 polynomial used by both transmitter and receiver.
package rx_controller_ear_pkg;

  localparam logic [7:0]  PREAMBLE_TAIL = 8'hAA;
  localparam logic [7:0]  SFD           = 8'hAB;
  localparam int unsigned HDR_BITS      = 8;
  localparam int unsigned CRC_BITS      = 8;
  localparam int unsigned ID_W          = 2;
  localparam int unsigned LEN_W         = 4;
  localparam int unsigned DATA_W        = 128;
  localparam logic [7:0]  CRC_POLY      = 8'h07;

  typedef enum logic [2:0] {
    S_HUNT,
    S_HEADER,
    S_DATA,
    S_CRC,
    S_DONE
  } rx_state_t;

  // Index of the final payload bit for a frame of len bytes (len >= 1).
  function automatic logic [7:0] data_bits_last(input logic [LEN_W-1:0] len);
    return {1'b0, len, 3'b000} - 8'd1;
  endfunction

endpackage

// File: rtl/rx_controller_ear_if.sv
// Receive-side result bus of rx_controller_ear: frame fields, valid pulse and busy flag.
interface rx_controller_ear_if;
  import rx_controller_ear_pkg::*;

  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic [LEN_W-1:0]  rx_len;
  logic [ID_W-1:0]   rx_src_id;
  logic [ID_W-1:0]   rx_dest_id;
  logic              rx_crc_err;
  logic              rx_busy;

  modport master (
    output rx_valid, rx_data, rx_len, rx_src_id, rx_dest_id, rx_crc_err, rx_busy
  );

  modport slave (
    input  rx_valid, rx_data, rx_len, rx_src_id, rx_dest_id, rx_crc_err, rx_busy
  );

endinterface

// File: rtl/rx_controller_ear_crc8.sv
// crc8_serial: bit-serial CRC-8 (poly 0x07, init 0x00, MSB first), shared with the transmitter.
module crc8_serial
  import rx_controller_ear_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_in,
  output logic [7:0] crc_out
);

  logic feedback;
  assign feedback = crc_out[7] ^ data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_out <= '0;
    end else if (clear) begin
      crc_out <= '0;
    end else if (enable) begin
      crc_out <= {crc_out[6:0], 1'b0} ^ (feedback ? CRC_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/rx_controller_ear.sv
// Serial frame receiver: preamble/SFD hunt, header, payload, CRC check, result delivery.
// Optional build macro RX_ADDR_FILTER_EN drops frames whose dest differs from my_id.
module rx_controller_ear
  import rx_controller_ear_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_line,
  input  logic [ID_W-1:0] my_id,
  rx_controller_ear_if.master rx
);

  rx_state_t         state, state_nxt;
  logic [15:0]       history;
  logic [7:0]        cnt;
  logic [7:0]        hdr_q;
  logic [7:0]        hdr_full;
  logic [DATA_W-1:0] payload;
  logic [7:0]        crc_rx;
  logic [7:0]        crc_calc;
  logic [6:0]        pidx;
  logic              bit_in;
  logic              sfd_hit;
  logic              crc_clear;
  logic              crc_en;
  logic              deliver;

  // Frame bits are consumed one cycle late from history[0], keeping hunt and capture aligned.
  assign bit_in   = history[0];
  assign sfd_hit  = (history == {PREAMBLE_TAIL, SFD});
  assign hdr_full = {hdr_q[6:0], bit_in};
  assign pidx     = 7'd127 - cnt[6:0];

`ifdef RX_ADDR_FILTER_EN
  logic [ID_W-1:0] my_id_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 my_id_q <= '0;
    else if (state == S_HEADER && cnt == 8'd7)  my_id_q <= my_id;
  end
  assign deliver = (hdr_q[7:6] == my_id_q);
`else
  logic my_id_unused;
  assign my_id_unused = ^my_id;
  assign deliver      = 1'b1;
`endif

  crc8_serial u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (crc_clear),
    .enable  (crc_en),
    .data_in (bit_in),
    .crc_out (crc_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
    unique case (state)
      S_HUNT: begin
        if (sfd_hit) begin
          state_nxt = S_HEADER;
          crc_clear = 1'b1;
        end
      end
      S_HEADER: begin
        if (cnt == 8'd7) state_nxt = (hdr_full[3:0] == '0) ? S_HUNT : S_DATA;
      end
      S_DATA: begin
        crc_en = 1'b1;
        if (cnt == data_bits_last(hdr_q[3:0])) state_nxt = S_CRC;
      end
      S_CRC: begin
        if (cnt == 8'd7) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_HUNT;
      default: state_nxt = S_HUNT;
    endcase
  end

  assign rx.rx_busy = (state != S_HUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history       <= '0;
      cnt           <= '0;
      hdr_q         <= '0;
      payload       <= '0;
      crc_rx        <= '0;
      rx.rx_valid   <= 1'b0;
      rx.rx_data    <= '0;
      rx.rx_len     <= '0;
      rx.rx_src_id  <= '0;
      rx.rx_dest_id <= '0;
      rx.rx_crc_err <= 1'b0;
    end else begin
      history     <= {history[14:0], rx_line};
      cnt         <= (state == S_HUNT || state_nxt != state) ? 8'd0 : cnt + 8'd1;
      rx.rx_valid <= 1'b0;
      if (state == S_HEADER) begin
        hdr_q <= hdr_full;
        if (cnt == 8'd7) payload <= '0;
      end
      if (state == S_DATA) payload[pidx] <= bit_in;
      if (state == S_CRC)  crc_rx <= {crc_rx[6:0], bit_in};
      if (state == S_DONE && deliver) begin
        rx.rx_valid   <= 1'b1;
        rx.rx_data    <= payload;
        rx.rx_len     <= hdr_q[3:0];
        rx.rx_src_id  <= hdr_q[5:4];
        rx.rx_dest_id <= hdr_q[7:6];
        rx.rx_crc_err <= (crc_rx != crc_calc);
      end
    end
  end

endmodule

// File: tb/tb_rx_controller_ear.sv
// Directed bench for rx_controller_ear: serial frames built by a bench-side transmitter model.
module tb_rx_controller_ear;
  import rx_controller_ear_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b0;
  logic [1:0] my_id = 2'd1;

  rx_controller_ear_if rx ();

  rx_controller_ear dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_line (rx_line),
    .my_id   (my_id),
    .rx      (rx)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned valid_cnt = 0;

  always @(negedge clk) if (rx.rx_valid) valid_cnt++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [127:0] d, input int unsigned nbits);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int unsigned i = 0; i < nbits; i++) begin
      fb = c[7] ^ d[127-i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Drives the low n bits of v, MSB first, one per clock on the falling edge.
  task automatic send_bits(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      rx_line = v[i];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_line = 1'b0;
    end
  endtask

  task automatic send_head(input logic [1:0] dest, input logic [1:0] src, input logic [3:0] len);
    send_bits(128'({PREAMBLE_TAIL, SFD}), 16);
    send_bits(128'({dest, src, len}), 8);
  endtask

  task automatic send_body(input logic [127:0] data, input logic [3:0] len, input logic flip);
    logic [127:0] line;
    line = data;
    if (flip) line[127] = ~line[127];
    for (int i = 0; i < int'(len) * 8; i++) begin
      @(negedge clk);
      rx_line = line[127-i];
    end
    send_bits(128'(crc8(data, int'(len) * 8)), 8);
  endtask

  // Latency counted in rising edges after the edge that samples the last CRC bit.
  task automatic wait_valid(output int lat);
    lat = -1;
    @(posedge clk);
    #1 rx_line = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (rx.rx_valid && lat < 0) lat = i;
    end
    @(negedge clk);
  endtask

  int          lat;
  int unsigned v0;

  initial begin
    idle(4);
    check("reset_valid", 128'(rx.rx_valid), 128'd0);
    check("reset_busy",  128'(rx.rx_busy),  128'd0);
    rst_n = 1'b1;
    idle(4);
    check("post_reset_data", rx.rx_data, 128'd0);
    check("post_reset_len",  128'(rx.rx_len), 128'd0);
    check("post_reset_ids",  128'({rx.rx_src_id, rx.rx_dest_id}), 128'd0);
    check("post_reset_err",  128'(rx.rx_crc_err), 128'd0);

    // Basic loopback frame
    v0 = valid_cnt;
    send_head(2'd1, 2'd2, 4'd4);
    check("A_busy_in_frame", 128'(rx.rx_busy), 128'd1);
    send_body(128'hDEADBEEF << 96, 4'd4, 1'b0);
    wait_valid(lat);
    check("A_latency", 128'(lat), 128'd2);
    check("A_count",   128'(valid_cnt - v0), 128'd1);
    check("A_data",    rx.rx_data, 128'hDEADBEEF << 96);
    check("A_len",     128'(rx.rx_len), 128'd4);
    check("A_src",     128'(rx.rx_src_id), 128'd2);
    check("A_dest",    128'(rx.rx_dest_id), 128'd1);
    check("A_crc_err", 128'(rx.rx_crc_err), 128'd0);
    check("A_busy_after", 128'(rx.rx_busy), 128'd0);
    idle(5);

    // Payload bit 127 corrupted on the line
    v0 = valid_cnt;
    send_head(2'd1, 2'd2, 4'd4);
    send_body(128'hDEADBEEF << 96, 4'd4, 1'b1);
    wait_valid(lat);
    check("B_count",   128'(valid_cnt - v0), 128'd1);
    check("B_data",    rx.rx_data, 128'h5EADBEEF << 96);
    check("B_crc_err", 128'(rx.rx_crc_err), 128'd1);
    idle(5);

    // Maximum length, all-ones payload
    v0 = valid_cnt;
    send_head(2'd1, 2'd3, 4'd15);
    send_body({128{1'b1}} << 8, 4'd15, 1'b0);
    wait_valid(lat);
    check("C_count",   128'(valid_cnt - v0), 128'd1);
    check("C_data",    rx.rx_data, {{120{1'b1}}, 8'h00});
    check("C_len",     128'(rx.rx_len), 128'd15);
    check("C_crc_err", 128'(rx.rx_crc_err), 128'd0);
    idle(5);

    // Zero-length header is dropped; previous results hold
    v0 = valid_cnt;
    send_head(2'd1, 2'd2, 4'd0);
    @(negedge clk);
    rx_line = 1'b0;
    check("Z_busy_hdr_end", 128'(rx.rx_busy), 128'd1);
    @(negedge clk);
    check("Z_busy_dropped", 128'(rx.rx_busy), 128'd0);
    idle(150);
    check("Z_count",    128'(valid_cnt - v0), 128'd0);
    check("Z_hold_len", 128'(rx.rx_len), 128'd15);
    check("Z_hold_src", 128'(rx.rx_src_id), 128'd3);

    // Reset in the middle of the payload
    v0 = valid_cnt;
    send_head(2'd1, 2'd3, 4'd8);
    send_bits(128'h000CAFE5, 20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("R_data", rx.rx_data, 128'd0);
    check("R_len",  128'(rx.rx_len), 128'd0);
    check("R_src",  128'(rx.rx_src_id), 128'd0);
    check("R_busy", 128'(rx.rx_busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(60);
    check("R_count", 128'(valid_cnt - v0), 128'd0);
    send_head(2'd1, 2'd2, 4'd4);
    send_body(128'hDEADBEEF << 96, 4'd4, 1'b0);
    wait_valid(lat);
    check("R2_count",   128'(valid_cnt - v0), 128'd1);
    check("R2_data",    rx.rx_data, 128'hDEADBEEF << 96);
    check("R2_crc_err", 128'(rx.rx_crc_err), 128'd0);
    idle(5);

    // Back-to-back frames with no idle gap
    v0 = valid_cnt;
    send_head(2'd1, 2'd1, 4'd1);
    send_body(128'h5A << 120, 4'd1, 1'b0);
    send_head(2'd1, 2'd3, 4'd2);
    send_body(128'h1234 << 112, 4'd2, 1'b0);
    wait_valid(lat);
    check("BB_count",   128'(valid_cnt - v0), 128'd2);
    check("BB_data",    rx.rx_data, 128'h1234 << 112);
    check("BB_src",     128'(rx.rx_src_id), 128'd3);
    check("BB_crc_err", 128'(rx.rx_crc_err), 128'd0);
    idle(5);

`ifdef RX_ADDR_FILTER_EN
    v0 = valid_cnt;
    send_head(2'd2, 2'd2, 4'd4);
    send_body(128'hDEADBEEF << 96, 4'd4, 1'b0);
    wait_valid(lat);
    check("F_drop_count", 128'(valid_cnt - v0), 128'd0);
    check("F_drop_hold",  rx.rx_data, 128'h1234 << 112);
    check("F_drop_busy",  128'(rx.rx_busy), 128'd0);
    idle(5);
    v0 = valid_cnt;
    send_head(2'd1, 2'd0, 4'd1);
    send_body(128'hC3 << 120, 4'd1, 1'b0);
    wait_valid(lat);
    check("F_pass_count", 128'(valid_cnt - v0), 128'd1);
    check("F_pass_data",  rx.rx_data, 128'hC3 << 120);
`else
    v0 = valid_cnt;
    send_head(2'd2, 2'd0, 4'd1);
    send_body(128'h3C << 120, 4'd1, 1'b0);
    wait_valid(lat);
    check("F_any_count", 128'(valid_cnt - v0), 128'd1);
    check("F_any_dest",  128'(rx.rx_dest_id), 128'd2);
    check("F_any_data",  rx.rx_data, 128'h3C << 120);
`endif

    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
